// File: rtl/vending_pkg.sv
// Shared types for the vending machine change path: denomination codes, their values
// and the change-dispenser FSM states.
package vending_pkg;

    typedef enum logic [1:0] {
        DENOM_ONE    = 2'b00,
        DENOM_FIVE   = 2'b01,
        DENOM_TEN    = 2'b10,
        DENOM_TWENTY = 2'b11
    } denom_t;

    localparam int unsigned VALUE_ONE    = 1;
    localparam int unsigned VALUE_FIVE   = 5;
    localparam int unsigned VALUE_TEN    = 10;
    localparam int unsigned VALUE_TWENTY = 20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_DISPENSE,
        ST_DONE
    } state_t;

    function automatic int unsigned denom_value(input logic [1:0] code);
        case (code)
            DENOM_ONE:    return VALUE_ONE;
            DENOM_FIVE:   return VALUE_FIVE;
            DENOM_TEN:    return VALUE_TEN;
            default:      return VALUE_TWENTY;
        endcase
    endfunction

endpackage

// File: rtl/denom_select.sv
// Combinational greedy chooser: largest available denomination whose value fits the
// remaining amount.
module denom_select
    import vending_pkg::*;
#(
    parameter int AMOUNT_W = 5
) (
    input  logic [AMOUNT_W-1:0] remaining,
    input  logic [3:0]          avail,
    output logic [1:0]          denom,
    output logic [AMOUNT_W-1:0] value,
    output logic                found
);

    logic [3:0] fits;

    for (genvar gi = 0; gi < 4; gi++) begin : g_fit
        assign fits[gi] = avail[gi] && (32'(remaining) >= denom_value(2'(gi)));
    end

    // Ascending scan so the highest fitting code is the one that sticks.
    always_comb begin
        denom = DENOM_ONE;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (fits[i]) begin
                denom = 2'(i);
                found = 1'b1;
            end
        end
    end

    assign value = AMOUNT_W'(denom_value(denom));

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: returns an amount one note/coin per valid/ready transfer, largest first.
// Optional per-denomination stock tracking is enabled by defining INVENTORY_EN.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int AMOUNT_W   = 5,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 15
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                start_i,
    input  logic [AMOUNT_W-1:0] change_amount_i,
    input  logic                dispense_ready_i,
    output logic                dispense_valid_o,
    output logic [1:0]          dispense_denom_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                short_o,
    output logic [AMOUNT_W-1:0] remaining_o,
    output logic [AMOUNT_W-1:0] num_twenty_o,
    output logic [AMOUNT_W-1:0] num_ten_o,
    output logic [AMOUNT_W-1:0] num_five_o,
    output logic [AMOUNT_W-1:0] num_one_o,
    input  logic                refill_i
);

    state_t              state_reg, state_next;
    logic [AMOUNT_W-1:0] remaining_reg, remaining_next;
    logic [AMOUNT_W-1:0] value_reg, value_next;
    logic [AMOUNT_W-1:0] tally_reg [4];
    logic [AMOUNT_W-1:0] tally_next [4];
    logic                short_reg, short_next;
    logic                valid_reg, valid_next;
    logic [1:0]          denom_reg, denom_next;
    logic                accept;

    logic [3:0]          avail;
    logic [1:0]          sel_denom;
    logic [AMOUNT_W-1:0] sel_value;
    logic                sel_found;

    denom_select #(.AMOUNT_W(AMOUNT_W)) u_select (
        .remaining (remaining_reg),
        .avail     (avail),
        .denom     (sel_denom),
        .value     (sel_value),
        .found     (sel_found)
    );

`ifdef INVENTORY_EN
    for (genvar gi = 0; gi < 4; gi++) begin : g_stock
        logic [STOCK_W-1:0] stock_reg;

        // Refill takes priority over a simultaneous dispense.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                stock_reg <= STOCK_W'(STOCK_INIT);
            end else if (refill_i) begin
                stock_reg <= STOCK_W'(STOCK_INIT);
            end else if (accept && denom_reg == 2'(gi)) begin
                stock_reg <= stock_reg - STOCK_W'(1);
            end
        end

        assign avail[gi] = (stock_reg != '0);
    end
`else
    logic               unused_refill;
    logic [STOCK_W-1:0] unused_stock_init;

    assign avail             = 4'b1111;
    assign unused_refill     = refill_i;
    assign unused_stock_init = STOCK_W'(STOCK_INIT);
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg     <= ST_IDLE;
            remaining_reg <= '0;
            value_reg     <= '0;
            short_reg     <= 1'b0;
            valid_reg     <= 1'b0;
            denom_reg     <= DENOM_ONE;
            for (int i = 0; i < 4; i++) begin
                tally_reg[i] <= '0;
            end
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            value_reg     <= value_next;
            short_reg     <= short_next;
            valid_reg     <= valid_next;
            denom_reg     <= denom_next;
            for (int i = 0; i < 4; i++) begin
                tally_reg[i] <= tally_next[i];
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        value_next     = value_reg;
        short_next     = short_reg;
        valid_next     = valid_reg;
        denom_next     = denom_reg;
        accept         = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tally_next[i] = tally_reg[i];
        end

        case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    remaining_next = change_amount_i;
                    short_next     = 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        tally_next[i] = '0;
                    end
                    state_next = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (remaining_reg == '0) begin
                    state_next = ST_DONE;
                end else if (sel_found) begin
                    denom_next = sel_denom;
                    value_next = sel_value;
                    valid_next = 1'b1;
                    state_next = ST_DISPENSE;
                end else begin
                    short_next = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DISPENSE: begin
                if (dispense_ready_i) begin
                    accept         = 1'b1;
                    remaining_next = remaining_reg - value_reg;
                    if (tally_reg[denom_reg] != '1) begin
                        tally_next[denom_reg] = tally_reg[denom_reg] + AMOUNT_W'(1);
                    end
                    valid_next = 1'b0;
                    state_next = ST_SELECT;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign dispense_valid_o = valid_reg;
    assign dispense_denom_o = denom_reg;
    assign busy_o           = (state_reg != ST_IDLE);
    assign done_o           = (state_reg == ST_DONE);
    assign short_o          = short_reg;
    assign remaining_o      = remaining_reg;
    assign num_twenty_o     = tally_reg[DENOM_TWENTY];
    assign num_ten_o        = tally_reg[DENOM_TEN];
    assign num_five_o       = tally_reg[DENOM_FIVE];
    assign num_one_o        = tally_reg[DENOM_ONE];

endmodule
